// File: rtl/gmii_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : gmii_tx_framer                                                    |
// | Brief  : GMII transmit framer: preamble/SFD insertion, payload forwarding, |
// |          underrun/abort error signalling and inter-packet gap.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module gmii_tx_framer #(
  parameter int PRE_LEN = 7,
  parameter int IPG_LEN = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_srdy,
  output logic       c_drdy,
  input  logic [7:0] c_data,
  input  logic [1:0] c_code,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       stat_pkt,
  output logic       stat_err
);

  localparam logic [1:0] CODE_SOP = 2'd0;
  localparam logic [1:0] CODE_EOP = 2'd2;
  localparam logic [1:0] CODE_BAD = 2'd3;
  localparam logic [7:0] BYTE_PRE = 8'h55;
  localparam logic [7:0] BYTE_SFD = 8'hD5;
  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0] IPG_LAST = 8'(IPG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
    S_IPG  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic [7:0] txd_q, txd_d;
  logic       tx_en_q, tx_en_d;
  logic       tx_er_q, tx_er_d;
  logic       pkt_q, pkt_d;
  logic       err_q, err_d;
  logic       drdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      first_q <= 1'b0;
      txd_q   <= 8'd0;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      pkt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    txd_d   = 8'd0;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    pkt_d   = 1'b0;
    err_d   = 1'b0;
    drdy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_srdy) begin
          if (c_code == CODE_SOP) begin
            txd_d   = BYTE_PRE;
            tx_en_d = 1'b1;
            cnt_d   = 8'd1;
            state_d = (PRE_LEN == 1) ? S_SFD : S_PRE;
          end else begin
            drdy  = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        txd_d   = BYTE_PRE;
        tx_en_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == PRE_LAST) state_d = S_SFD;
      end
      S_SFD: begin
        txd_d   = BYTE_SFD;
        tx_en_d = 1'b1;
        first_d = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        tx_en_d = 1'b1;
        // The frame's own SOP byte is taken on the first beat; a later SOP aborts.
        if (!c_srdy) begin
          tx_er_d = 1'b1;
          err_d   = 1'b1;
        end else if ((c_code == CODE_SOP) && !first_q) begin
          tx_er_d = 1'b1;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IPG;
        end else begin
          drdy    = 1'b1;
          first_d = 1'b0;
          txd_d   = c_data;
          if (c_code == CODE_EOP) begin
            pkt_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_IPG;
          end else if (c_code == CODE_BAD) begin
            tx_er_d = 1'b1;
            err_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_IPG;
          end
        end
      end
      S_IPG: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == IPG_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign c_drdy     = drdy & ~reset;
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign stat_pkt   = pkt_q;
  assign stat_err   = err_q;

endmodule
`default_nettype wire
